// File: rtl/ddc_nco_decim.sv
// ddc_nco_decim: NCO + complex mixer + integrate-and-dump decimator; config swaps on window boundaries.
// Define DDC_SAT_EN to clamp outputs and drive a sticky sat_flag; otherwise outputs wrap.
module ddc_nco_decim #(
    parameter int  DW      = 16,
    parameter int  OW      = 16,
    parameter int  PW      = 32,
    parameter int  LUT_AW  = 10,
    parameter int  NCO_W   = 16,
    parameter real IF      = 50e6,
    parameter real FS      = 200e6,
    parameter int  DEC_RST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PW-1:0]        cfg_ftw,
    input  logic [7:0]           cfg_dec,
    input  logic [3:0]           cfg_shift,
    input  logic                 cfg_load,
    input  logic signed [DW-1:0] adc_in,
    input  logic                 adc_val,
    output logic signed [OW-1:0] I_out,
    output logic signed [OW-1:0] Q_out,
    output logic                 IQ_val,
    output logic                 sat_flag
);
    localparam int PRW = DW + NCO_W;
    localparam int AW = PRW + 8;
    localparam int N = 2 ** LUT_AW;
    localparam logic [PW-1:0] FTW_RST = PW'(longint'(IF / FS * (2.0 ** PW)));
    localparam logic [7:0] DEC_R = 8'(DEC_RST);
    localparam real PI = 3.14159265358979323846;
    localparam real AMP = 2.0 ** (NCO_W - 1) - 1.0;

    logic signed [NCO_W-1:0] cos_lut [N];
    logic signed [NCO_W-1:0] sin_lut [N];
    for (genvar k = 0; k < N; k++) begin : g_lut
        localparam real A = 2.0 * PI * k / N;
        assign cos_lut[k] = NCO_W'(int'($floor(AMP * $cos(A) + 0.5)));
        assign sin_lut[k] = NCO_W'(int'($floor(AMP * $sin(A) + 0.5)));
    end

    logic [PW-1:0] phase, ftw, sh_ftw, ftw_n;
    logic [7:0] dec, sh_dec, cnt, dec_in, dec_n;
    logic [3:0] shift, sh_shift, shift_n;
    logic pend, last, apply;
    logic s0_val, s0_last, s1_val, s1_last, s2_val, s2_last, dump, fresh;
    logic [3:0] s0_shift, s1_shift, s2_shift, d_shift;
    logic [LUT_AW-1:0] s0_addr;
    logic signed [DW-1:0] s0_x, s1_x;
    logic signed [NCO_W-1:0] s1_c, s1_s;
    logic signed [PRW-1:0] p_i, p_q;
    logic signed [AW-1:0] acc_i, acc_q;
    logic signed [OW-1:0] res_i, res_q;

    // a load coinciding with the closing sample bypasses the shadow registers
    always_comb begin
        dec_in = (cfg_dec == 8'd0) ? 8'd1 : cfg_dec;
        last = cnt == dec - 8'd1;
        apply = adc_val && last && (pend || cfg_load);
        ftw_n = apply ? (cfg_load ? cfg_ftw : sh_ftw) : ftw;
        dec_n = apply ? (cfg_load ? dec_in : sh_dec) : dec;
        shift_n = apply ? (cfg_load ? cfg_shift : sh_shift) : shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            ftw <= FTW_RST;
            sh_ftw <= FTW_RST;
            dec <= DEC_R;
            sh_dec <= DEC_R;
            shift <= '0;
            sh_shift <= '0;
            cnt <= '0;
            pend <= 1'b0;
        end else begin
            if (cfg_load) begin
                sh_ftw <= cfg_ftw;
                sh_dec <= dec_in;
                sh_shift <= cfg_shift;
            end
            pend <= !apply && (pend || cfg_load);
            ftw <= ftw_n;
            dec <= dec_n;
            shift <= shift_n;
            if (adc_val) begin
                phase <= phase + ftw_n;
                cnt <= last ? 8'd0 : cnt + 8'd1;
            end
        end
    end

    // the closing window's shift travels with its last tag down the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_val <= 1'b0;
            s0_last <= 1'b0;
            s0_shift <= '0;
            s0_addr <= '0;
            s0_x <= '0;
            s1_val <= 1'b0;
            s1_last <= 1'b0;
            s1_shift <= '0;
            s1_x <= '0;
            s1_c <= '0;
            s1_s <= '0;
            s2_val <= 1'b0;
            s2_last <= 1'b0;
            s2_shift <= '0;
            p_i <= '0;
            p_q <= '0;
            dump <= 1'b0;
            d_shift <= '0;
            acc_i <= '0;
            acc_q <= '0;
            fresh <= 1'b1;
            IQ_val <= 1'b0;
            I_out <= '0;
            Q_out <= '0;
        end else begin
            s0_val <= adc_val;
            s0_last <= adc_val && last;
            s0_shift <= shift;
            s0_addr <= phase[PW-1 -: LUT_AW];
            s0_x <= adc_in;
            s1_val <= s0_val;
            s1_last <= s0_last;
            s1_shift <= s0_shift;
            s1_x <= s0_x;
            s1_c <= cos_lut[s0_addr];
            s1_s <= sin_lut[s0_addr];
            s2_val <= s1_val;
            s2_last <= s1_last;
            s2_shift <= s1_shift;
            p_i <= PRW'(s1_x) * PRW'(s1_c);
            p_q <= -(PRW'(s1_x) * PRW'(s1_s));
            dump <= s2_val && s2_last;
            d_shift <= s2_shift;
            if (s2_val) begin
                acc_i <= fresh ? AW'(p_i) : acc_i + AW'(p_i);
                acc_q <= fresh ? AW'(p_q) : acc_q + AW'(p_q);
                fresh <= s2_last;
            end
            IQ_val <= dump;
            if (dump) begin
                I_out <= res_i;
                Q_out <= res_q;
            end
        end
    end

`ifdef DDC_SAT_EN
    localparam logic signed [AW-1:0] MAXV = AW'(2 ** (OW - 1) - 1);
    localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
    logic signed [AW-1:0] sh_i, sh_q;
    logic sat_i, sat_q;
    always_comb begin
        sh_i = acc_i >>> (NCO_W - 1 + int'(d_shift));
        sh_q = acc_q >>> (NCO_W - 1 + int'(d_shift));
        sat_i = sh_i > MAXV || sh_i < MINV;
        sat_q = sh_q > MAXV || sh_q < MINV;
        res_i = !sat_i ? sh_i[OW-1:0] : sh_i[AW-1] ? MINV[OW-1:0] : MAXV[OW-1:0];
        res_q = !sat_q ? sh_q[OW-1:0] : sh_q[AW-1] ? MINV[OW-1:0] : MAXV[OW-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (dump && (sat_i || sat_q))
            sat_flag <= 1'b1;
    end
`else
    always_comb begin
        res_i = OW'(acc_i >>> (NCO_W - 1 + int'(d_shift)));
        res_q = OW'(acc_q >>> (NCO_W - 1 + int'(d_shift)));
    end
    assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_ddc_nco_decim.sv
// tb_ddc_nco_decim: randomized bench for ddc_nco_decim against a window-sum reference model.
// Honours DDC_SAT_EN the same way as the design.
module tb_ddc_nco_decim;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] cfg_ftw = '0;
    logic [7:0] cfg_dec = '0;
    logic [3:0] cfg_shift = '0;
    logic cfg_load = 1'b0;
    logic signed [15:0] adc_in = '0;
    logic adc_val = 1'b0;
    logic signed [15:0] I_out, Q_out;
    logic IQ_val, sat_flag;

    ddc_nco_decim dut (
        .clk(clk), .rst_n(rst_n), .cfg_ftw(cfg_ftw), .cfg_dec(cfg_dec),
        .cfg_shift(cfg_shift), .cfg_load(cfg_load), .adc_in(adc_in), .adc_val(adc_val),
        .I_out(I_out), .Q_out(Q_out), .IQ_val(IQ_val), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        logic [15:0] i;
        logic [15:0] q;
        logic sat;
    } exp_t;

    exp_t q_exp[$];
    exp_t cur;
    int n_cmp = 0, n_bad = 0, edge_n = 0, n_pulse = 0;
    bit due;
    logic [31:0] m_phase, m_ftw, m_sh_ftw;
    int m_r, m_sh_r, m_shift, m_sh_shift, m_cnt;
    bit m_pend, m_sat;
    longint m_si, m_sq;
    logic [15:0] last_i, last_q;

    function automatic longint lut(input int idx, input bit s);
        real a;
        a = 2.0 * 3.14159265358979323846 * idx / 1024.0;
        return longint'($floor(32767.0 * (s ? $sin(a) : $cos(a)) + 0.5));
    endfunction

    function automatic logic [15:0] fit(input longint v);
`ifdef DDC_SAT_EN
        if (v > 32767) begin
            m_sat = 1'b1;
            return 16'h7fff;
        end
        if (v < -32768) begin
            m_sat = 1'b1;
            return 16'h8000;
        end
`endif
        return v[15:0];
    endfunction

    task automatic model_reset();
        m_phase = '0;
        m_ftw = 32'h4000_0000;
        m_sh_ftw = 32'h4000_0000;
        m_r = 1;
        m_sh_r = 1;
        m_shift = 0;
        m_sh_shift = 0;
        m_cnt = 0;
        m_pend = 1'b0;
        m_sat = 1'b0;
        m_si = 0;
        m_sq = 0;
        last_i = '0;
        last_q = '0;
        q_exp.delete();
    endtask

    // one clock: drive inputs, take the edge, advance the reference model
    task automatic step(input bit v, input logic signed [15:0] x, input bit ld,
                        input logic [31:0] f, input logic [7:0] d, input logic [3:0] s);
        int d_eff, idx;
        bit lst;
        logic [15:0] iv, qv;
        adc_val = v;
        adc_in = x;
        cfg_load = ld;
        cfg_ftw = f;
        cfg_dec = d;
        cfg_shift = s;
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            model_reset();
        end else begin
            d_eff = (d == 8'd0) ? 1 : int'(d);
            lst = 1'b0;
            if (v) begin
                idx = int'(m_phase[31:22]);
                m_si += longint'(x) * lut(idx, 1'b0);
                m_sq -= longint'(x) * lut(idx, 1'b1);
                m_cnt++;
                lst = m_cnt == m_r;
                if (lst) begin
                    iv = fit(m_si >>> (15 + m_shift));
                    qv = fit(m_sq >>> (15 + m_shift));
                    q_exp.push_back('{edge_n + 4, iv, qv, m_sat});
                    m_si = 0;
                    m_sq = 0;
                    m_cnt = 0;
                end
            end
            if (lst && (m_pend || ld)) begin
                m_ftw = ld ? f : m_sh_ftw;
                m_r = ld ? d_eff : m_sh_r;
                m_shift = ld ? int'(s) : m_sh_shift;
                m_pend = 1'b0;
            end else if (ld) begin
                m_pend = 1'b1;
            end
            if (ld) begin
                m_sh_ftw = f;
                m_sh_r = d_eff;
                m_sh_shift = int'(s);
            end
            if (v) m_phase += m_ftw;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    // every IQ_val pulse must land on its model cycle with the model's values; outputs hold otherwise
    always @(negedge clk) begin
        if (rst_n) begin
            due = q_exp.size() > 0 && q_exp[0].e == edge_n;
            if (IQ_val) n_pulse++;
            n_cmp++;
            if (IQ_val !== due) begin
                n_bad++;
                $display("FAIL iq_val_timing edge %0d: got %b want %b", edge_n, IQ_val, due);
            end
            if (due) begin
                cur = q_exp.pop_front();
                last_i = cur.i;
                last_q = cur.q;
                n_cmp++;
                if (I_out !== cur.i || Q_out !== cur.q || sat_flag !== cur.sat) begin
                    n_bad++;
                    $display("FAIL iq_value edge %0d: got I=%0d Q=%0d sat=%b want I=%0d Q=%0d sat=%b",
                             edge_n, I_out, Q_out, sat_flag, $signed(cur.i), $signed(cur.q), cur.sat);
                end
            end else begin
                n_cmp++;
                if (I_out !== last_i || Q_out !== last_q) begin
                    n_bad++;
                    $display("FAIL iq_hold edge %0d: got I=%0d Q=%0d want I=%0d Q=%0d",
                             edge_n, I_out, Q_out, $signed(last_i), $signed(last_q));
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({I_out, Q_out, IQ_val, sat_flag} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got I=%0d Q=%0d v=%b sat=%b want all 0", I_out, Q_out, IQ_val, sat_flag);
        end
    endtask

    task automatic test_dc();
        step(1'b0, '0, 1'b1, 32'd0, 8'd4, 4'd2);
        for (int i = 0; i < 17; i++) step(1'b1, 16'sd1000, 1'b0, '0, '0, '0);
        idle(6);
        n_cmp++;
        if (I_out !== 16'sd999 || Q_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL dc_ftw0: got I=%0d Q=%0d want I=999 Q=0", I_out, Q_out);
        end
    endtask

    task automatic test_fs4();
        step(1'b0, '0, 1'b1, 32'h4000_0000, 8'd4, 4'd2);
        for (int i = 0; i < 12; i++) step(1'b1, 16'sd1000, 1'b0, '0, '0, '0);
        idle(6);
        n_cmp++;
        if (I_out !== 16'sd0 || Q_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL fs4_const: got I=%0d Q=%0d want I=0 Q=0", I_out, Q_out);
        end
        // window starts at 90 degrees after the boundary, so the +/-1000 pattern lines up with cos peaks
        step(1'b1, 16'sd0, 1'b0, '0, '0, '0);
        step(1'b1, 16'(-1000), 1'b0, '0, '0, '0);
        step(1'b1, 16'sd0, 1'b0, '0, '0, '0);
        step(1'b1, 16'sd1000, 1'b0, '0, '0, '0);
        idle(6);
        n_cmp++;
        if (I_out !== 16'sd499 || Q_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL fs4_pattern: got I=%0d Q=%0d want I=499 Q=0", I_out, Q_out);
        end
    endtask

    task automatic test_cfg_mid();
        n_pulse = 0;
        step(1'b1, 16'($urandom), 1'b0, '0, '0, '0);
        step(1'b1, 16'($urandom), 1'b1, 32'h4000_0000, 8'd2, 4'd2);
        for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0, '0, '0, '0);
        step(1'b1, 16'($urandom), 1'b0, '0, '0, '0);
        step(1'b1, 16'($urandom), 1'b1, 32'h4000_0000, 8'd4, 4'd2);
        for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0, '0, '0, '0);
        idle(6);
        n_cmp++;
        if (n_pulse !== 6) begin
            n_bad++;
            $display("FAIL cfg_mid_pulses: got %0d want 6", n_pulse);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        n_pulse = 0;
        step(1'b1, 16'($urandom), 1'b0, '0, '0, '0);
        idle(2);
        step(1'b1, 16'($urandom), 1'b0, '0, '0, '0);
        step(1'b1, 16'($urandom), 1'b0, '0, '0, '0);
        idle(6);
        n_cmp++;
        if (n_pulse !== 3) begin
            n_bad++;
            $display("FAIL gaps_pulses: got %0d want 3", n_pulse);
        end
        for (int i = 0; i < 40; i++) step($urandom_range(0, 1) == 1, 16'($urandom), 1'b0, '0, '0, '0);
        idle(6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 19) == 0,
                 $urandom, 8'($urandom_range(0, 8)), 4'($urandom_range(0, 15)));
        idle(8);
    endtask

    task automatic test_sat();
`ifdef DDC_SAT_EN
        logic [16:0] want = {1'b1, 16'd32767};
`else
        logic [16:0] want = {1'b0, 16'd32258};
`endif
        do_reset();
        step(1'b0, '0, 1'b1, 32'd0, 8'd255, 4'd0);
        for (int i = 0; i < 256; i++) step(1'b1, 16'sd32767, 1'b0, '0, '0, '0);
        idle(6);
        n_cmp++;
        if ({sat_flag, I_out} !== want) begin
            n_bad++;
            $display("FAIL sat_r255: got sat=%b I=%0d want sat=%b I=%0d", sat_flag, I_out, want[16], want[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        n_pulse = 0;
        step(1'b0, '0, 1'b1, 32'h1234_5678, 8'd3, 4'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom), 1'b0, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({I_out, Q_out, IQ_val, sat_flag} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got I=%0d Q=%0d v=%b sat=%b want all 0", I_out, Q_out, IQ_val, sat_flag);
        end
        idle(1);
        rst_n = 1'b1;
        step(1'b1, 16'sd1000, 1'b0, '0, '0, '0);
        idle(5);
        n_cmp++;
        if (I_out !== 16'sd999 || Q_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL reset_ftw_s0: got I=%0d Q=%0d want I=999 Q=0", I_out, Q_out);
        end
        step(1'b1, 16'sd1000, 1'b0, '0, '0, '0);
        idle(5);
        n_cmp++;
        if (I_out !== 16'sd0 || Q_out !== -16'sd1000) begin
            n_bad++;
            $display("FAIL reset_ftw_s1: got I=%0d Q=%0d want I=0 Q=-1000", I_out, Q_out);
        end
        n_cmp++;
        if (n_pulse !== 2) begin
            n_bad++;
            $display("FAIL reset_mid_pulses: got %0d want 2", n_pulse);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dc();
        test_fs4();
        test_cfg_mid();
        test_gaps();
        test_random();
        test_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
